// File: rtl/bitwise_pkg.sv
// Shared encodings for the bit-serial bitwise unit: operation codes and FSM states.
package bitwise_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bitwise_slice.sv
// One SLICE-bit lane of the bitwise unit. Purely combinational; the top
// time-multiplexes this single instance across all slices of the operands.
module bitwise_slice
    import bitwise_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [1:0]       op,
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    output logic [SLICE-1:0] y_s
);

    // Select the requested bitwise function for this slice.
    always_comb begin
        y_s = '0;
        case (op)
            OP_AND:  y_s = a_s & b_s;
            OP_OR:   y_s = a_s | b_s;
            OP_XOR:  y_s = a_s ^ b_s;
            OP_NAND: y_s = ~(a_s & b_s);
            default: y_s = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_serial.sv
// Bit-serial AND/OR/XOR/NAND unit: processes SLICE bits per cycle, LSB slice
// first, behind a start/busy/done handshake. Operands and op are captured when
// start is accepted (IDLE or DONE), so the inputs may change during RUN.
// Handshake: start is sampled only while not busy; done is a one-cycle pulse
// in DONE, and out/zero change only on the edge that enters DONE.
// Optional feature: define BITWISE_SERIAL_ZERO_EN to add the registered zero flag.
module bitwise_serial
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
`ifdef BITWISE_SERIAL_ZERO_EN
    ,
    output logic             zero
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   work_next;
    logic [SLICE-1:0]   a_s, b_s, y_s;
`ifdef BITWISE_SERIAL_ZERO_EN
    logic               zero_q, zero_d;
`endif

    // Pick the current slice of the latched operands for the shared lane.
    always_comb begin
        a_s = a_q[int'(idx_q)*SLICE +: SLICE];
        b_s = b_q[int'(idx_q)*SLICE +: SLICE];
    end

    bitwise_slice #(.SLICE(SLICE)) u_slice (
        .op  (op_q),
        .a_s (a_s),
        .b_s (b_s),
        .y_s (y_s)
    );

    // Next-state logic: operand capture, slice stepping and result publication.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        work_d    = work_q;
        out_d     = out_q;
`ifdef BITWISE_SERIAL_ZERO_EN
        zero_d    = zero_q;
`endif
        work_next = work_q;
        work_next[int'(idx_q)*SLICE +: SLICE] = y_s;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                work_d = work_next;
                if (idx_q == IDX_LAST) begin
                    // Final slice: the merged value is complete, publish it.
                    out_d   = work_next;
`ifdef BITWISE_SERIAL_ZERO_EN
                    zero_d  = (work_next == '0);
`endif
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            work_q  <= '0;
            out_q   <= '0;
`ifdef BITWISE_SERIAL_ZERO_EN
            zero_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            work_q  <= work_d;
            out_q   <= out_d;
`ifdef BITWISE_SERIAL_ZERO_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign out  = out_q;
`ifdef BITWISE_SERIAL_ZERO_EN
    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_bitwise_serial.sv
// Directed bench for bitwise_serial: a 16/4 instance driven from a vector
// table plus hand-written multi-cycle sequences, and an 8/8 instance for the
// single-slice case. Zero-flag checks are active with BITWISE_SERIAL_ZERO_EN.
module tb_bitwise_serial;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        busy, done;
    logic [15:0] out;
    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  out8;
`ifdef BITWISE_SERIAL_ZERO_EN
    logic        zero, zero8;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
    } vec_t;
    vec_t vecs[9];

    bitwise_serial #(.WIDTH(16), .SLICE(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out)
`ifdef BITWISE_SERIAL_ZERO_EN
        ,
        .zero  (zero)
`endif
    );

    bitwise_serial #(.WIDTH(8), .SLICE(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .op    (op8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .out   (out8)
`ifdef BITWISE_SERIAL_ZERO_EN
        ,
        .zero  (zero8)
`endif
    );

    // Clock starts only once clk_en is raised, so reset can be checked clockless.
    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called just after the accepting edge; waits for done and checks it.
    task automatic wait_done(input string nm);
        int n;
        logic [15:0] held;
        logic [15:0] exp;
        bit stable;
        n = 0;
        held = out;
        stable = 1'b1;
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        while (!done && n < 20) begin
            if (out !== held) stable = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        exp = exp_q.pop_front();
        chk({nm, "_latency"}, 32'(n), 32'd4);
        chk({nm, "_no_partial"}, 32'(stable), 32'd1);
        chk({nm, "_out"}, 32'(out), 32'(exp));
        chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
`ifdef BITWISE_SERIAL_ZERO_EN
        chk({nm, "_zero"}, 32'(zero), 32'(exp == 16'h0000));
`endif
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
        chk({nm, "_out_hold"}, 32'(out), 32'(exp));
    endtask

    initial begin
        int n, t1, t2;
        bit seen;

        vecs[0] = '{2'b00, 16'hF0F0, 16'hFF00, 16'hF000};
        vecs[1] = '{2'b01, 16'h1200, 16'h0034, 16'h1234};
        vecs[2] = '{2'b10, 16'hAAAA, 16'h5555, 16'hFFFF};
        vecs[3] = '{2'b11, 16'hFFFF, 16'h00FF, 16'hFF00};
        vecs[4] = '{2'b11, 16'h0F0F, 16'hFFFF, 16'hF0F0};
        vecs[5] = '{2'b00, 16'hA5A5, 16'h0FF0, 16'h05A0};
        vecs[6] = '{2'b10, 16'h1234, 16'h1234, 16'h0000};
        vecs[7] = '{2'b11, 16'h0000, 16'h0000, 16'hFFFF};
        vecs[8] = '{2'b01, 16'h8001, 16'h0180, 16'h8181};

        // Reset with no clock running.
        reset = 1'b1;
        start = 1'b0; op = 2'b00; a = '0; b = '0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", 32'(out), 32'h0000);
        chk("rst_out8", 32'(out8), 32'h00);
`ifdef BITWISE_SERIAL_ZERO_EN
        chk("rst_zero", 32'(zero), 32'd1);
`endif
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // Table-driven single operations.
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(vecs[i].y);
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i));
        end

        // XOR with operand A changed right after the accepting edge.
        exp_q.push_back(16'h0000);
        start_op(2'b10, 16'hAAAA, 16'hAAAA);
        a = 16'h1234;
        wait_done("xor_capture");

        // Back-to-back NAND with start held high throughout.
        op = 2'b11; a = 16'hFFFF; b = 16'h00FF; start = 1'b1;
        @(posedge clk); #1;
        a = 16'h0F0F; b = 16'hFFFF;
        n = 0;
        while (!done && n < 20) begin @(posedge clk); #1; n++; end
        t1 = cyc;
        chk("b2b_lat1", 32'(n), 32'd4);
        chk("b2b_out1", 32'(out), 32'hFF00);
        @(posedge clk); #1;
        chk("b2b_accept2", 32'(busy), 32'd1);
        chk("b2b_done_drop", 32'(done), 32'd0);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin @(posedge clk); #1; n++; end
        t2 = cyc;
        chk("b2b_lat2", 32'(n), 32'd4);
        chk("b2b_gap", 32'(t2 - t1), 32'd5);
        chk("b2b_out2", 32'(out), 32'hF0F0);
        @(posedge clk); #1;

        // Single-slice instance: done one cycle after start.
        op8 = 2'b00; a8 = 8'h3C; b8 = 8'h0F; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("w8_busy", 32'(busy8), 32'd1);
        chk("w8_done_early", 32'(done8), 32'd0);
        @(posedge clk); #1;
        chk("w8_done", 32'(done8), 32'd1);
        chk("w8_out", 32'(out8), 32'h0C);
        chk("w8_busy_at_done", 32'(busy8), 32'd0);
`ifdef BITWISE_SERIAL_ZERO_EN
        chk("w8_zero", 32'(zero8), 32'd0);
`endif
        @(posedge clk); #1;
        chk("w8_done_pulse", 32'(done8), 32'd0);

        // Reset two RUN cycles into an OR operation.
        start_op(2'b01, 16'h1200, 16'h0034);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_out", 32'(out), 32'h0000);
        chk("mid_rst_out8", 32'(out8), 32'h00);
`ifdef BITWISE_SERIAL_ZERO_EN
        chk("mid_rst_zero", 32'(zero), 32'd1);
`endif
        @(posedge clk);
        #2 reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("mid_rst_no_done", 32'(seen), 32'd0);
        exp_q.push_back(16'h1234);
        start_op(2'b01, 16'h1200, 16'h0034);
        wait_done("after_rst");

        // Reset while done is high drops it asynchronously.
        start_op(2'b00, 16'hFFFF, 16'hFFFF);
        n = 0;
        while (!done && n < 20) begin @(posedge clk); #1; n++; end
        chk("done_rst_pre", 32'(done), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("done_rst_drop", 32'(done), 32'd0);
        chk("done_rst_out", 32'(out), 32'h0000);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
